// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters for the fetch stage.
// The prediction is registered one cycle after the lookup; EXEC trains it via the update port.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookupEn,
  input  logic [XLEN-1:0] lookupPc,
  output logic            predValid,
  output logic            predTaken,
  output logic [XLEN-1:0] predTarget,
  output logic            ready,
  input  logic            updEn,
  input  logic [XLEN-1:0] updPc,
  input  logic            updTaken,
  input  logic [XLEN-1:0] updTarget,
  input  logic            updJmp,
  input  logic            flush
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] WEAK = CNT_W'(1 << (CNT_W - 1));

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  clr_idx, clr_idx_nx;
  logic              clr_en;

  logic [ENTRIES-1:0] ent_valid;
  logic [TAG_W-1:0]   ent_tag [ENTRIES];
  logic [XLEN-1:0]    ent_tgt [ENTRIES];
  logic [CNT_W-1:0]   ent_cnt [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, lk_taken;
  logic              up_hit, upd_do, upd_wr, upd_wr_tgt, upd_alloc;
  logic [CNT_W-1:0]  upd_cnt;
  logic              unused_upd_pc;

  assign lk_idx = lookupPc[IDX_W+1:2];
  assign lk_tag = lookupPc[IDX_W+1+TAG_W:IDX_W+2];
  assign up_idx = updPc[IDX_W+1:2];
  assign up_tag = updPc[IDX_W+1+TAG_W:IDX_W+2];
  assign unused_upd_pc = ^updPc;

  assign ready    = (state == S_RUN);
  assign lk_hit   = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ent_cnt[lk_idx][CNT_W-1];
  assign up_hit   = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
  // flush takes priority over a same-cycle update
  assign upd_do   = ready && updEn && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    clr_en     = 1'b0;
    case (state)
      S_INIT: begin
        clr_en = 1'b1;
        if (flush) begin
          clr_idx_nx = '0;
        end else begin
          clr_idx_nx = clr_idx + 1'b1;
          if (clr_idx == IDX_W'(ENTRIES - 1)) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_nx   = S_INIT;
          clr_idx_nx = '0;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    upd_cnt    = ent_cnt[up_idx];
    upd_wr     = 1'b0;
    upd_wr_tgt = 1'b0;
    upd_alloc  = 1'b0;
    if (up_hit) begin
      upd_wr = 1'b1;
      if (updJmp) begin
        upd_cnt    = CMAX;
        upd_wr_tgt = 1'b1;
      end else if (updTaken) begin
        upd_cnt    = (upd_cnt == CMAX) ? CMAX : upd_cnt + 1'b1;
        upd_wr_tgt = 1'b1;
      end else begin
        upd_cnt = (upd_cnt == '0) ? '0 : upd_cnt - 1'b1;
      end
    end else if (updTaken || updJmp) begin
      upd_wr     = 1'b1;
      upd_wr_tgt = 1'b1;
      upd_alloc  = 1'b1;
      upd_cnt    = updJmp ? CMAX : WEAK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
    end else if (clr_en) begin
      ent_valid[clr_idx] <= 1'b0;
    end else if (upd_do && upd_alloc) begin
      ent_valid[up_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset: nothing reads them until the entry is valid.
  always_ff @(posedge clk) begin
    if (upd_do && upd_wr) begin
      ent_cnt[up_idx] <= upd_cnt;
      if (upd_wr_tgt) ent_tgt[up_idx] <= updTarget;
      if (upd_alloc)  ent_tag[up_idx] <= up_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predValid  <= 1'b0;
      predTaken  <= 1'b0;
      predTarget <= '0;
    end else if (lookupEn && ready) begin
      predValid  <= 1'b1;
      predTaken  <= lk_taken;
      predTarget <= lk_taken ? ent_tgt[lk_idx] : lookupPc + XLEN'(4);
    end else begin
      predValid  <= 1'b0;
    end
  end

endmodule
